// File: rtl/soc_l2_axi_port.sv
// AXI4 slave front-end for one L2 SRAM bank: one transaction at a time, one beat per
// SRAM access. The AXI_BUS port is flattened into slv_* signals.
module soc_l2_axi_port #(
  parameter int unsigned AXI_AW      = 32,
  parameter int unsigned AXI_DW      = 64,
  parameter int unsigned AXI_IW      = 4,
  parameter int unsigned AXI_UW      = 2,
  parameter int unsigned MEM_N_BYTES = 4096,
  localparam int unsigned BYTE_BITS  = $clog2(AXI_DW / 8),
  localparam int unsigned BANK_BITS  = $clog2(MEM_N_BYTES),
  localparam int unsigned MEM_AW     = BANK_BITS - BYTE_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AXI_IW-1:0]     slv_aw_id,
  input  logic [AXI_AW-1:0]     slv_aw_addr,
  input  logic [7:0]            slv_aw_len,
  input  logic [2:0]            slv_aw_size,
  input  logic [1:0]            slv_aw_burst,
  input  logic [AXI_UW-1:0]     slv_aw_user,
  input  logic                  slv_aw_valid,
  output logic                  slv_aw_ready,
  input  logic [AXI_DW-1:0]     slv_w_data,
  input  logic [AXI_DW/8-1:0]   slv_w_strb,
  input  logic                  slv_w_last,
  input  logic                  slv_w_valid,
  output logic                  slv_w_ready,
  output logic [AXI_IW-1:0]     slv_b_id,
  output logic [1:0]            slv_b_resp,
  output logic [AXI_UW-1:0]     slv_b_user,
  output logic                  slv_b_valid,
  input  logic                  slv_b_ready,
  input  logic [AXI_IW-1:0]     slv_ar_id,
  input  logic [AXI_AW-1:0]     slv_ar_addr,
  input  logic [7:0]            slv_ar_len,
  input  logic [2:0]            slv_ar_size,
  input  logic [1:0]            slv_ar_burst,
  input  logic [AXI_UW-1:0]     slv_ar_user,
  input  logic                  slv_ar_valid,
  output logic                  slv_ar_ready,
  output logic [AXI_IW-1:0]     slv_r_id,
  output logic [AXI_DW-1:0]     slv_r_data,
  output logic [1:0]            slv_r_resp,
  output logic                  slv_r_last,
  output logic [AXI_UW-1:0]     slv_r_user,
  output logic                  slv_r_valid,
  input  logic                  slv_r_ready,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [AXI_DW-1:0]     mem_wdata_o,
  output logic [AXI_DW/8-1:0]   mem_be_o,
  input  logic [AXI_DW-1:0]     mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e state_q, state_d;

  logic                aw_ready_q, ar_ready_q;
  logic                read_last_q;
  logic                rd_first_q;
  logic [AXI_IW-1:0]   id_q;
  logic [AXI_AW-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [AXI_UW-1:0]   user_q;
  logic [AXI_DW-1:0]   rdata_q;
  logic [AXI_AW-1:0]   addr_next;
  logic                aw_hs, ar_hs, w_hs, r_hs;
  logic                addr_unused;

  assign aw_hs = slv_aw_valid & aw_ready_q;
  assign ar_hs = slv_ar_valid & ar_ready_q;
  assign w_hs  = slv_w_valid & (state_q == WR_DATA);
  assign r_hs  = slv_r_ready & (state_q == RD_RESP);

  // WRAP bursts are deliberately advanced like INCR; FIXED keeps the address.
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (AXI_AW'(1) << size_q);

  assign slv_aw_ready = aw_ready_q;
  assign slv_ar_ready = ar_ready_q;
  assign slv_b_id     = id_q;
  assign slv_b_resp   = 2'b00;
  assign slv_b_user   = user_q;
  assign slv_r_id     = id_q;
  assign slv_r_resp   = 2'b00;
  assign slv_r_user   = user_q;
  assign slv_r_last   = (state_q == RD_RESP) && (beat_q == len_q);
  assign mem_addr_o   = addr_q[BANK_BITS-1:BYTE_BITS];
  assign addr_unused  = ^addr_q;

  // SRAM data is live only in the first response cycle; later cycles use the captured copy.
  assign slv_r_data = rd_first_q ? mem_rdata_i : rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_ready_q  <= 1'b0;
      ar_ready_q  <= 1'b0;
      read_last_q <= 1'b1;
      rd_first_q  <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      user_q      <= '0;
      rdata_q     <= '0;
    end else begin
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      // Ready is a registered one-cycle pulse; on a tie the channel not served last wins.
      if (state_q == IDLE && !aw_ready_q && !ar_ready_q) begin
        if (slv_aw_valid && (!slv_ar_valid || read_last_q)) begin
          aw_ready_q <= 1'b1;
        end else if (slv_ar_valid) begin
          ar_ready_q <= 1'b1;
        end
      end
      if (aw_hs) begin
        id_q        <= slv_aw_id;
        addr_q      <= slv_aw_addr;
        len_q       <= slv_aw_len;
        size_q      <= slv_aw_size;
        burst_q     <= slv_aw_burst;
        user_q      <= slv_aw_user;
        beat_q      <= '0;
        read_last_q <= 1'b0;
      end
      if (ar_hs) begin
        id_q        <= slv_ar_id;
        addr_q      <= slv_ar_addr;
        len_q       <= slv_ar_len;
        size_q      <= slv_ar_size;
        burst_q     <= slv_ar_burst;
        user_q      <= slv_ar_user;
        beat_q      <= '0;
        read_last_q <= 1'b1;
      end
      if (w_hs || r_hs) begin
        addr_q <= addr_next;
      end
      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
      end
      rd_first_q <= (state_q == RD_REQ);
      if (rd_first_q) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    slv_w_ready = 1'b0;
    slv_b_valid = 1'b0;
    slv_r_valid = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WR_DATA;
        end else if (ar_hs) begin
          state_d = RD_REQ;
        end
      end
      WR_DATA: begin
        slv_w_ready = 1'b1;
        mem_req_o   = slv_w_valid;
        mem_we_o    = 1'b1;
        mem_be_o    = slv_w_strb;
        mem_wdata_o = slv_w_data;
        if (w_hs && slv_w_last) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        slv_b_valid = 1'b1;
        if (slv_b_ready) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        mem_req_o = 1'b1;
        mem_be_o  = '1;
        state_d   = RD_RESP;
      end
      RD_RESP: begin
        slv_r_valid = 1'b1;
        if (r_hs) begin
          state_d = slv_r_last ? IDLE : RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_l2_axi_port.sv
// Directed bench for soc_l2_axi_port: a transaction-level model predicts every SRAM
// access and every B/R response, and one negedge process compares the DUT against it.
module tb_soc_l2_axi_port;

  localparam int AW = 32, DW = 64, IW = 4, UW = 2;
  localparam int MEM_BYTES = 4096, WORDS = 512, MAW = 9;

  logic clk_i, rst_ni;
  logic [IW-1:0] slv_aw_id, slv_ar_id, slv_b_id, slv_r_id;
  logic [AW-1:0] slv_aw_addr, slv_ar_addr;
  logic [7:0] slv_aw_len, slv_ar_len, slv_w_strb, mem_be_o;
  logic [2:0] slv_aw_size, slv_ar_size;
  logic [1:0] slv_aw_burst, slv_ar_burst, slv_b_resp, slv_r_resp;
  logic [UW-1:0] slv_aw_user, slv_ar_user, slv_b_user, slv_r_user;
  logic slv_aw_valid, slv_aw_ready, slv_ar_valid, slv_ar_ready;
  logic [DW-1:0] slv_w_data, slv_r_data, mem_wdata_o, mem_rdata_i;
  logic slv_w_last, slv_w_valid, slv_w_ready, slv_b_valid, slv_b_ready;
  logic slv_r_last, slv_r_valid, slv_r_ready;
  logic mem_req_o, mem_we_o;
  logic [MAW-1:0] mem_addr_o;

  soc_l2_axi_port #(.AXI_AW(AW), .AXI_DW(DW), .AXI_IW(IW), .AXI_UW(UW), .MEM_N_BYTES(MEM_BYTES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slv_aw_id(slv_aw_id), .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len),
    .slv_aw_size(slv_aw_size), .slv_aw_burst(slv_aw_burst), .slv_aw_user(slv_aw_user),
    .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
    .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last),
    .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
    .slv_b_id(slv_b_id), .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user),
    .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
    .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len),
    .slv_ar_size(slv_ar_size), .slv_ar_burst(slv_ar_burst), .slv_ar_user(slv_ar_user),
    .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
    .slv_r_id(slv_r_id), .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp),
    .slv_r_last(slv_r_last), .slv_r_user(slv_r_user),
    .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total_cnt = 0;
  int bad_cnt = 0;

  typedef struct { logic we; logic [MAW-1:0] addr; logic [63:0] data; logic [7:0] be; } mem_op_t;
  typedef struct { logic [IW-1:0] id; logic [UW-1:0] user; } b_exp_t;
  typedef struct { logic [63:0] data; logic [IW-1:0] id; logic [UW-1:0] user; logic last; } r_exp_t;

  mem_op_t exp_mem[$];
  b_exp_t  exp_b[$];
  r_exp_t  exp_r[$];
  logic [63:0] ref_mem [WORDS];

  int          obs_addr[$];
  logic [7:0]  obs_be[$];
  logic        obs_last[$];
  logic [63:0] obs_rdata[$];
  logic [IW-1:0] obs_bid[$];

  function automatic logic [63:0] init_word(int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 32) | 64'(i * 3 + 1);
  endfunction

  function automatic logic [63:0] wdata_of(logic [31:0] addr, int beat);
    return {addr, 24'hC0FFEE, 8'(beat)};
  endfunction

  // Byte address of beat n = start + n * 2^size (unless FIXED), folded into the bank.
  function automatic int word_of(logic [31:0] addr, int beat, logic [2:0] size, logic [1:0] burst);
    longint a;
    a = longint'(addr);
    if (burst != 2'b00) a = a + longint'(beat) * (longint'(1) << size);
    return int'((a % MEM_BYTES) / 8);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  // SRAM stand-in: one-cycle read latency, byte-enabled writes.
  logic [63:0] sram [WORDS];
  bit sram_ready = 1'b0;
  always @(posedge clk_i) begin
    if (!sram_ready) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 8; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  mem_op_t     cmp_op;
  b_exp_t      cmp_b;
  r_exp_t      cmp_r;
  logic        prev_r_stall;
  logic [63:0] prev_r_data;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_r_stall <= 1'b0;
    end else begin
      if (mem_req_o) begin
        obs_addr.push_back(int'(mem_addr_o));
        obs_be.push_back(mem_be_o);
        if (exp_mem.size() == 0) begin
          check_output("mem_unexpected", 1, 0);
        end else begin
          cmp_op = exp_mem.pop_front();
          check_output("mem_we", mem_we_o, cmp_op.we);
          check_output("mem_addr", mem_addr_o, cmp_op.addr);
          check_output("mem_be", mem_be_o, cmp_op.be);
          if (cmp_op.we) check_output("mem_wdata", mem_wdata_o, cmp_op.data);
        end
      end
      if (slv_b_valid) begin
        if (exp_b.size() == 0) begin
          check_output("b_unexpected", 1, 0);
        end else if (slv_b_ready) begin
          cmp_b = exp_b.pop_front();
          obs_bid.push_back(slv_b_id);
          check_output("b_id", slv_b_id, cmp_b.id);
          check_output("b_user", slv_b_user, cmp_b.user);
          check_output("b_resp", slv_b_resp, 2'b00);
        end
      end
      if (slv_r_valid && prev_r_stall) check_output("r_data_stable", slv_r_data, prev_r_data);
      if (slv_r_valid) begin
        if (exp_r.size() == 0) begin
          check_output("r_unexpected", 1, 0);
        end else if (slv_r_ready) begin
          cmp_r = exp_r.pop_front();
          obs_last.push_back(slv_r_last);
          obs_rdata.push_back(slv_r_data);
          check_output("r_data", slv_r_data, cmp_r.data);
          check_output("r_id", slv_r_id, cmp_r.id);
          check_output("r_user", slv_r_user, cmp_r.user);
          check_output("r_last", slv_r_last, cmp_r.last);
          check_output("r_resp", slv_r_resp, 2'b00);
        end
      end
      prev_r_stall <= slv_r_valid && !slv_r_ready;
      prev_r_data  <= slv_r_data;
    end
  end

  task automatic expect_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [IW-1:0] id,
                              input logic [UW-1:0] user, input logic [7:0] strb);
    mem_op_t op;
    b_exp_t  bx;
    for (int i = 0; i <= len; i++) begin
      op.we = 1'b1;
      op.addr = MAW'(word_of(addr, i, size, burst));
      op.data = wdata_of(addr, i);
      op.be = strb;
      exp_mem.push_back(op);
      for (int b = 0; b < 8; b++)
        if (strb[b]) ref_mem[op.addr][b*8 +: 8] = op.data[b*8 +: 8];
    end
    bx.id = id;
    bx.user = user;
    exp_b.push_back(bx);
  endtask

  task automatic expect_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [IW-1:0] id,
                             input logic [UW-1:0] user);
    mem_op_t op;
    r_exp_t  rx;
    for (int i = 0; i <= len; i++) begin
      op.we = 1'b0;
      op.addr = MAW'(word_of(addr, i, size, burst));
      op.data = '0;
      op.be = 8'hFF;
      exp_mem.push_back(op);
      rx.data = ref_mem[op.addr];
      rx.id = id;
      rx.user = user;
      rx.last = (i == len);
      exp_r.push_back(rx);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic sig_of(int which);
    case (which)
      0: return slv_aw_ready;
      1: return slv_ar_ready;
      2: return slv_w_ready;
      3: return slv_b_valid;
      4: return slv_r_valid;
      default: return slv_aw_ready | slv_ar_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (sig_of(which)) return;
    end
    check_output({name, "_timeout"}, 0, 1);
  endtask

  task automatic apply_stimulus_aw(input logic [31:0] addr, input int len, input logic [2:0] size,
                                   input logic [1:0] burst, input logic [IW-1:0] id,
                                   input logic [UW-1:0] user);
    slv_aw_addr = addr; slv_aw_len = 8'(len); slv_aw_size = size;
    slv_aw_burst = burst; slv_aw_id = id; slv_aw_user = user; slv_aw_valid = 1'b1;
  endtask

  task automatic apply_stimulus_ar(input logic [31:0] addr, input int len, input logic [2:0] size,
                                   input logic [1:0] burst, input logic [IW-1:0] id,
                                   input logic [UW-1:0] user);
    slv_ar_addr = addr; slv_ar_len = 8'(len); slv_ar_size = size;
    slv_ar_burst = burst; slv_ar_id = id; slv_ar_user = user; slv_ar_valid = 1'b1;
  endtask

  task automatic finish_addr(input bit wr);
    wait_sig(wr ? 0 : 1, wr ? "aw_ready" : "ar_ready");
    sync();
    if (wr) slv_aw_valid = 1'b0;
    else slv_ar_valid = 1'b0;
  endtask

  task automatic send_wdata(input logic [31:0] addr, input int len, input logic [7:0] strb);
    for (int i = 0; i <= len; i++) begin
      slv_w_valid = 1'b1;
      slv_w_data = wdata_of(addr, i);
      slv_w_strb = strb;
      slv_w_last = (i == len);
      wait_sig(2, "w_ready");
      sync();
    end
    slv_w_valid = 1'b0;
    slv_w_last = 1'b0;
  endtask

  task automatic recv_b(input int low_cycles);
    wait_sig(3, "b_valid");
    repeat (low_cycles - 1) begin
      @(negedge clk_i);
      check_output("b_valid_held", slv_b_valid, 1);
    end
    sync();
    slv_b_ready = 1'b1;
    sync();
    slv_b_ready = 1'b0;
    @(negedge clk_i);
    check_output("b_valid_released", slv_b_valid, 0);
    sync();
  endtask

  task automatic recv_r(input int beats, input int low_cycles);
    for (int i = 0; i < beats; i++) begin
      wait_sig(4, "r_valid");
      if (i == 0) repeat (low_cycles - 1) @(negedge clk_i);
      sync();
      slv_r_ready = 1'b1;
      sync();
      slv_r_ready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id,
                          input logic [UW-1:0] user, input logic [7:0] strb, input int b_low);
    expect_write(addr, len, size, burst, id, user, strb);
    apply_stimulus_aw(addr, len, size, burst, id, user);
    finish_addr(1'b1);
    send_wdata(addr, len, strb);
    recv_b(b_low);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id,
                         input logic [UW-1:0] user, input int r_low);
    expect_read(addr, len, size, burst, id, user);
    apply_stimulus_ar(addr, len, size, burst, id, user);
    finish_addr(1'b0);
    recv_r(len + 1, r_low);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_be.delete(); obs_last.delete(); obs_rdata.delete(); obs_bid.delete();
  endtask

  task automatic tie_round(input logic [31:0] addr, input logic [IW-1:0] wid, input logic [IW-1:0] rid,
                           input string name);
    expect_write(addr, 1, 3'd3, 2'b01, wid, 2'd1, 8'hFF);
    expect_read(addr, 1, 3'd3, 2'b01, rid, 2'd2);
    apply_stimulus_aw(addr, 1, 3'd3, 2'b01, wid, 2'd1);
    apply_stimulus_ar(addr, 1, 3'd3, 2'b01, rid, 2'd2);
    wait_sig(5, name);
    check_output({name, "_aw_ready"}, slv_aw_ready, 1);
    check_output({name, "_ar_ready"}, slv_ar_ready, 0);
    sync();
    slv_aw_valid = 1'b0;
    @(negedge clk_i);
    check_output({name, "_aw_ready_pulse"}, slv_aw_ready, 0);
    sync();
    send_wdata(addr, 1, 8'hFF);
    recv_b(1);
    finish_addr(1'b0);
    recv_r(2, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    rst_ni = 1'b0;
    slv_aw_valid = 0; slv_ar_valid = 0; slv_w_valid = 0; slv_w_last = 0;
    slv_b_ready = 0; slv_r_ready = 0;
    slv_aw_id = 0; slv_aw_addr = 0; slv_aw_len = 0; slv_aw_size = 0; slv_aw_burst = 0; slv_aw_user = 0;
    slv_ar_id = 0; slv_ar_addr = 0; slv_ar_len = 0; slv_ar_size = 0; slv_ar_burst = 0; slv_ar_user = 0;
    slv_w_data = 0; slv_w_strb = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_output("reset_readies", {slv_aw_ready, slv_ar_ready, slv_w_ready}, 0);
    check_output("reset_valids", {slv_b_valid, slv_r_valid}, 0);
    check_output("reset_mem", {mem_req_o, mem_we_o, mem_be_o}, 0);
    sync();
    rst_ni = 1'b1;
    sync();

    $display("[TB] tie arbitration from reset");
    tie_round(32'h1C00_0200, 4'd2, 4'd3, "tie1");
    tie_round(32'h1C00_0300, 4'd4, 4'd6, "tie2");

    $display("[TB] write INCR len 3");
    clear_obs();
    do_write(32'h1C00_0010, 3, 3'd3, 2'b01, 4'h5, 2'd0, 8'hFF, 1);
    check_output("w4_count", obs_addr.size(), 4);
    check_output("w4_addr0", obs_addr[0], 2);
    check_output("w4_addr3", obs_addr[3], 5);
    check_output("w4_bid", obs_bid[0], 4'h5);

    $display("[TB] read INCR len 1 with r_ready stall");
    clear_obs();
    do_read(32'h1C00_0000, 1, 3'd3, 2'b01, 4'h1, 2'd0, 3);
    check_output("r2_addr0", obs_addr[0], 0);
    check_output("r2_addr1", obs_addr[1], 1);
    check_output("r2_last0", obs_last[0], 0);
    check_output("r2_last1", obs_last[1], 1);
    check_output("r2_data0", obs_rdata[0], 64'hA5A5_0000_0000_0001);
    check_output("r2_data1", obs_rdata[1], 64'hA5A5_0001_0000_0004);

    $display("[TB] read FIXED len 3");
    clear_obs();
    do_read(32'h1C00_0040, 3, 3'd3, 2'b00, 4'h7, 2'd3, 1);
    check_output("fixed_count", obs_addr.size(), 4);
    check_output("fixed_addr0", obs_addr[0], 8);
    check_output("fixed_addr3", obs_addr[3], 8);

    $display("[TB] write len 0 with b_ready stall");
    clear_obs();
    do_write(32'h1C00_0080, 0, 3'd3, 2'b01, 4'h9, 2'd1, 8'h0F, 5);
    check_output("be_count", obs_addr.size(), 1);
    check_output("be_value", obs_be[0], 8'h0F);

    $display("[TB] narrow write and readback");
    clear_obs();
    do_write(32'h1C00_0100, 3, 3'd2, 2'b01, 4'h1, 2'd0, 8'hFF, 1);
    check_output("narrow_addr1", obs_addr[1], 32);
    check_output("narrow_addr2", obs_addr[2], 33);
    do_read(32'h1C00_0100, 0, 3'd3, 2'b01, 4'h2, 2'd0, 1);

    $display("[TB] read WRAP treated as INCR");
    clear_obs();
    do_read(32'h1C00_0038, 1, 3'd3, 2'b10, 4'h3, 2'd1, 2);
    check_output("wrap_addr1", obs_addr[1], 8);

    $display("[TB] read len 255 across bank end");
    clear_obs();
    do_read(32'h1C00_0F00, 255, 3'd3, 2'b01, 4'hF, 2'd0, 1);
    check_output("long_count", obs_addr.size(), 256);
    check_output("long_first", obs_addr[0], 480);
    check_output("long_wrapped", obs_addr[32], 0);
    check_output("long_final", obs_addr[255], 223);

    $display("[TB] reset during write beat 2 of 4");
    begin
      mem_op_t op;
      op.we = 1'b1; op.addr = 9'd128; op.data = wdata_of(32'h1C00_0400, 0); op.be = 8'hFF;
      exp_mem.push_back(op);
      ref_mem[128] = op.data;
    end
    apply_stimulus_aw(32'h1C00_0400, 3, 3'd3, 2'b01, 4'hA, 2'd0);
    finish_addr(1'b1);
    slv_w_valid = 1'b1; slv_w_data = wdata_of(32'h1C00_0400, 0); slv_w_strb = 8'hFF; slv_w_last = 1'b0;
    wait_sig(2, "abort_w_ready");
    sync();
    slv_w_data = wdata_of(32'h1C00_0400, 1);
    rst_ni = 1'b0;
    #1;
    check_output("abort_mem_req", mem_req_o, 0);
    check_output("abort_mem_we", mem_we_o, 0);
    check_output("abort_mem_bus", {mem_be_o, mem_wdata_o}, 0);
    check_output("abort_w_ready", slv_w_ready, 0);
    check_output("abort_valids", {slv_b_valid, slv_r_valid, slv_aw_ready, slv_ar_ready}, 0);
    sync();
    slv_w_valid = 1'b0;
    sync();
    rst_ni = 1'b1;
    repeat (8) begin
      @(negedge clk_i);
      check_output("abort_no_b", slv_b_valid, 0);
    end
    sync();
    do_read(32'h1C00_0400, 1, 3'd3, 2'b01, 4'hB, 2'd0, 1);

    repeat (4) sync();
    check_output("left_mem_ops", exp_mem.size(), 0);
    check_output("left_b", exp_b.size(), 0);
    check_output("left_r", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
